// File: rtl/mult4_share_arbiter_pkg.sv
// Shared types and constants for the shared 4x4 multiplier arbiter.
// Holds the FSM state encoding and the tag-width helper.
package mult4_share_pkg;

  localparam int DW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult4_share_arbiter_mult.sv
// Truncating 4x4 multiplier: s = (a*b) mod 16.
// The 4-bit result context discards the high product bits.
module Multiplier_4x4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [3:0] o_s
);

  // Low nibble of the product only.
  assign o_s = i_a * i_b;

endmodule

// File: rtl/mult4_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Grants the first requester at or above ptr, wrapping mod N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_any = 1'b1;
        o_idx = IW'((int'(i_ptr) + k) % N);
        o_gnt = '0;
        o_gnt[(int'(i_ptr) + k) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult4_share_arbiter.sv
// Round-robin share of one 4x4 multiplier among N_REQ requesters.
// One op in flight: IDLE accepts, CALC multiplies, RESP waits for the consumer.
module mult4_share_arbiter
  import mult4_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = 4,
  parameter int CNT_W = 8,
  localparam int ID_W = id_w(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [DW-1:0]       rsp_data,
  output logic                busy,
  output logic [CNT_W-1:0]    done_cnt
);

  state_t           r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [DW-1:0]    r_a;
  logic [DW-1:0]    r_b;
  logic [ID_W-1:0]  r_id;

  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_idx;
  logic             w_any;
  logic             w_accept;
  logic [DW-1:0]    w_a;
  logic [DW-1:0]    w_b;
  logic [DW-1:0]    w_prod;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  Multiplier_4x4 u_mul (
    .i_a (r_a),
    .i_b (r_b),
    .o_s (w_prod)
  );

  // Grant is only exposed while idle; a grant implies its valid is set.
  assign req_ready = (r_state == IDLE) ? w_gnt : '0;
  assign w_accept  = (r_state == IDLE) && w_any;
  assign w_a       = req_a[w_idx*DW +: DW];
  assign w_b       = req_b[w_idx*DW +: DW];
  assign busy      = (r_state != IDLE);

  // Control FSM with operand, tag, pointer and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_id      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      done_cnt  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= w_a;
            r_b     <= w_b;
            r_id    <= w_idx;
            r_ptr   <= (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          rsp_data  <= w_prod;
          rsp_id    <= r_id;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            done_cnt  <= done_cnt + 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult4_share_arbiter.sv
// Bench for mult4_share_arbiter: transaction model plus directed vectors.
// Model tracks one outstanding op and its age, not the DUT state machine.
module tb_mult4_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_data;
  logic        busy;
  logic [7:0]  done_cnt;

  always #5 clk = ~clk;

  mult4_share_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model state: one outstanding op, its age in cycles after accept.
  bit m_out;
  int m_age;
  int m_id;
  int m_data;
  int m_ptr;
  int m_cnt;
  int cyc;
  int acc_id[$];
  int acc_cyc[$];
  int rsp_id_q[$];
  int rsp_dat_q[$];
  int rsp_cyc[$];

  function automatic int grant(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin
    int g;
    cyc++;
    if (!rst_n) begin
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_id", 32'(rsp_id), 32'd0);
      chk("rst_data", 32'(rsp_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt", 32'(done_cnt), 32'd0);
      m_out = 0;
      m_age = 0;
      m_ptr = 0;
      m_cnt = 0;
    end else begin
      g = m_out ? -1 : grant(req_valid, m_ptr);
      chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
      chk("busy", 32'(busy), 32'(m_out));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_out && m_age >= 1));
      if (m_out && m_age >= 1) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_data", 32'(rsp_data), 32'(m_data));
      end
      chk("done_cnt", 32'(done_cnt), 32'(m_cnt));
      if (g >= 0) begin
        m_out  = 1;
        m_age  = 0;
        m_id   = g;
        m_data = (int'(req_a[g*4 +: 4]) * int'(req_b[g*4 +: 4])) % 16;
        m_ptr  = (g + 1) % 4;
        acc_id.push_back(g);
        acc_cyc.push_back(cyc);
      end else if (m_out) begin
        if (m_age >= 1 && rsp_ready) begin
          m_out = 0;
          m_cnt = (m_cnt + 1) % 256;
          rsp_id_q.push_back(int'(rsp_id));
          rsp_dat_q.push_back(int'(rsp_data));
          rsp_cyc.push_back(cyc);
        end else begin
          m_age++;
        end
      end
    end
  end

  task automatic wait_acc(input int n);
    int k = 0;
    while (acc_id.size() < n && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("acc_timeout", 32'(acc_id.size() >= n), 32'd1);
  endtask

  task automatic wait_rsp(input int n, input int lim);
    int k = 0;
    while (rsp_id_q.size() < n && k < lim) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rsp_timeout", 32'(rsp_id_q.size() >= n), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run_one(input int idx, input logic [3:0] a,
                         input logic [3:0] b, input int eid, input int edat);
    int n;
    int r;
    n = acc_id.size();
    r = rsp_id_q.size();
    req_a[idx*4 +: 4] = a;
    req_b[idx*4 +: 4] = b;
    req_valid = 4'(1 << idx);
    wait_acc(n + 1);
    req_valid = 4'b0000;
    req_a[idx*4 +: 4] = ~a;
    req_b[idx*4 +: 4] = ~b;
    wait_rsp(r + 1, 50);
    if (rsp_id_q.size() > r) begin
      chk("lit_id", 32'(rsp_id_q[r]), 32'(eid));
      chk("lit_data", 32'(rsp_dat_q[r]), 32'(edat));
    end
  endtask

  initial begin
    int n;
    int r;
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    do_reset();
    chk("init_cnt", 32'(done_cnt), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);

    // Single op from requester 0: 3*5 = 0xF, two-cycle latency.
    rsp_ready = 1'b1;
    req_a[3:0] = 4'd3;
    req_b[3:0] = 4'd5;
    req_valid = 4'b0001;
    #1 chk("t2_ready", 32'(req_ready), 32'h1);
    n = acc_id.size();
    r = rsp_id_q.size();
    wait_acc(n + 1);
    req_valid = 4'b0000;
    wait_rsp(r + 1, 50);
    if (rsp_id_q.size() > r) begin
      chk("t2_id", 32'(rsp_id_q[r]), 32'd0);
      chk("t2_data", 32'(rsp_dat_q[r]), 32'hF);
      chk("t2_lat", 32'(rsp_cyc[r] - acc_cyc[n]), 32'd2);
    end
    chk("t2_cnt", 32'(done_cnt), 32'd1);

    // Truncation cases.
    run_one(2, 4'd7, 4'd6, 2, 4'hA);
    run_one(1, 4'hF, 4'hF, 1, 4'h1);

    // All requesters held: rotation 0,1,2,3,0 every 3 cycles.
    do_reset();
    req_a = 16'h4321;
    req_b = 16'h5432;
    req_valid = 4'b1111;
    n = acc_id.size();
    r = rsp_id_q.size();
    wait_acc(n + 5);
    req_valid = 4'b0000;
    wait_rsp(r + 5, 50);
    if (acc_id.size() >= n + 5) begin
      for (int k = 0; k < 5; k++)
        chk("t4_order", 32'(acc_id[n + k]), 32'(k % 4));
      for (int k = 0; k < 4; k++)
        chk("t4_gap", 32'(acc_cyc[n + k + 1] - acc_cyc[n + k]), 32'd3);
    end
    if (rsp_id_q.size() >= r + 5)
      chk("t4_data3", 32'(rsp_dat_q[r + 3]), 32'd4);

    // Stalled response: 2*3 = 6 from requester 3 held for 5 cycles.
    rsp_ready = 1'b0;
    req_a[15:12] = 4'd2;
    req_b[15:12] = 4'd3;
    req_valid = 4'b1000;
    n = acc_id.size();
    wait_acc(n + 1);
    req_valid = 4'b1111;
    req_a[15:12] = 4'd9;
    @(posedge clk); #1;
    repeat (5) begin
      chk("t5_valid", 32'(rsp_valid), 32'd1);
      chk("t5_data", 32'(rsp_data), 32'd6);
      chk("t5_id", 32'(rsp_id), 32'd3);
      chk("t5_ready", 32'(req_ready), 32'd0);
      chk("t5_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_idle", 32'(busy), 32'd0);
    req_valid = 4'b0000;

    // Reset during CALC drops the op and restarts the pointer.
    req_a[11:8] = 4'd5;
    req_b[11:8] = 4'd5;
    req_valid = 4'b0100;
    n = acc_id.size();
    wait_acc(n + 1);
    r = rsp_id_q.size();
    rst_n = 1'b0;
    #1;
    chk("t6_async_busy", 32'(busy), 32'd0);
    chk("t6_async_cnt", 32'(done_cnt), 32'd0);
    chk("t6_async_valid", 32'(rsp_valid), 32'd0);
    req_valid = 4'b0000;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("t6_no_rsp", 32'(rsp_id_q.size()), 32'(r));
    req_valid = 4'b1111;
    #1 chk("t6_ptr0", 32'(req_ready), 32'h1);

    // 256 completions wrap the counter.
    req_a[3:0] = 4'd1;
    req_b[3:0] = 4'd1;
    req_valid = 4'b0001;
    r = rsp_id_q.size();
    wait_rsp(r + 256, 900);
    req_valid = 4'b0000;
    chk("t6_wrap", 32'(done_cnt), 32'd0);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
